mips_mem_responder: RTL
=======================

// Module: mips_mem_responder
//
// PURPOSE
//   Responder side of the core's memory interface: one 1024x32 word array
//   that serves instruction-fetch reads (IF) and load/store accesses (MEM).
//   A req/ack handshake with programmable wait states replaces the core's
//   zero-latency Mem[] indexing.
//   A one-cycle program-load port fills the array while the core is halted.
//   Sits between the mips pipeline and the testbench/program loader.
//
// PARAMETERS
//   ADDR_W       10    word-address width; DEPTH = 2**ADDR_W words
//   DATA_W       32    word width
//   WAIT_CYCLES  1     extra BUSY cycles per access (0..15)
//
// PORTS
//   clk1      in   1       single clock, all state on posedge
//   rst       in   1       synchronous, active-high reset
//   if_req    in   1       fetch request, held high until if_ack
//   if_addr   in   ADDR_W  fetch word address (PC)
//   if_rdata  out  DATA_W  fetched word, valid while if_ack=1
//   if_ack    out  1       one-cycle fetch completion pulse
//   dm_req    in   1       data request, held high until dm_ack
//   dm_we     in   1       1=store (SW), 0=load (LW)
//   dm_addr   in   ADDR_W  data word address (EX_MEM_ALUOut)
//   dm_wdata  in   DATA_W  store data (EX_MEM_B)
//   dm_rdata  out  DATA_W  load data, valid while dm_ack=1
//   dm_ack    out  1       one-cycle data completion pulse
//   ld_en     in   1       program-load write strobe
//   ld_addr   in   ADDR_W  program-load address
//   ld_data   in   DATA_W  program-load word
//   busy      out  1       1 whenever FSM is not IDLE
//
// BEHAVIOUR
//   Reset: state=IDLE, cnt=0, if_ack=dm_ack=0, if_rdata=dm_rdata=0, busy=0.
//     Array contents are NOT reset.
//   FSM states:
//     IDLE -> BUSY: when any req=1 or ld_en=1 is sampled.
//     BUSY -> RESP: when cnt==0; otherwise cnt decrements each cycle.
//     RESP -> IDLE: unconditionally.
//   IDLE sampling priority: ld_en > dm_req > if_req.
//     ld_en in IDLE: Mem[ld_addr]<=ld_data at that edge; stays IDLE, no ack.
//       ld_en outside IDLE is ignored.
//     Grant: latch port id, addr, we, wdata; cnt<=WAIT_CYCLES; go BUSY.
//   Access at the edge leaving BUSY (cnt==0):
//     read: granted rdata<=Mem[addr];  write: Mem[addr]<=wdata, dm_rdata holds.
//     The granted ack goes high in RESP, for exactly one cycle.
//   Latency: req sampled at edge N -> ack sampled high at edge N+WAIT_CYCLES+2.
//     Next IDLE sample at N+WAIT_CYCLES+3.
//   Requester may drop req, or change it for a new access, on the edge where it
//     samples ack. RESP never samples req, so a held req is not re-granted.
//   Simultaneous if_req & dm_req: dm served first (older instruction); if_req
//     stays pending and is granted on the next IDLE. No starvation: dm cannot
//     issue again until the core advances.
//   req dropped before ack: protocol violation; the latched access still
//     completes and acks (no abort).
//   rdata outputs hold their last value between acks; the non-granted ack
//     stays 0.
//   Reset mid-BUSY: access abandoned, no array write, no ack, state=IDLE.
//   Read-after-write same address, back-to-back: the read returns new data.
//   Addresses are exactly ADDR_W bits, so out-of-range access is impossible.
//
// STRUCTURE
//   Shared package mips_pkg: state encoding (IDLE/BUSY/RESP), port-id enum
//     (PORT_IF, PORT_DM), opcode constants LW/SW shared with the core.
//   Sub-module mips_mem_array: single-port synchronous RAM (we, addr, wdata,
//     rdata), DEPTH x DATA_W.
//   FSM, arbiter, wait counter and load mux stay in this module.
//
// TESTING
//   1 Reset: rst=1 for 2 cycles with if_req=1 -> acks=0, busy=0, rdata=0 hold.
//   2 Load+fetch: ld_en writes Mem[0]=32'h2801000A; if_req, if_addr=0
//     -> if_ack at edge N+3 (W=1), if_rdata=32'h2801000A.
//   3 Store/load: dm_we=1, dm_addr=120, dm_wdata=85, then a load of 120
//     -> dm_ack twice, dm_rdata=85 on the second ack.
//   4 Contention: if_req & dm_req rise together (dm load of 5, Mem[5]=7)
//     -> dm_ack first with 7; if_ack follows W+3 cycles later.
//   5 Reset mid-op: store 32'hDEAD to addr 9, rst during BUSY
//     -> no dm_ack; a later load of 9 returns the old value.
//   6 WAIT_CYCLES=0 and 4: a read acks at N+2 and at N+6 respectively;
//     busy is high for 2 and 6 cycles.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the mips core and its memory responder.
package mips_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef enum logic {PORT_IF, PORT_DM} port_t;

  localparam logic [5:0] LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011;

endpackage

// File: rtl/mips_mem_array.sv
// Single-port synchronous word RAM; a read updates rdata, a write leaves it alone.
module mips_mem_array #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk1,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk1) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/mips_mem_responder.sv
// Memory responder: arbitrates IF/MEM requests onto one RAM with programmable
// wait states; program loads write straight through while idle.
module mips_mem_responder
  import mips_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              busy
);

  state_t            state, state_nxt;
  port_t             port_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
  logic              grant, ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  // Loads win over both requesters; dm beats if since it is the older instruction.
  assign grant = (state == IDLE) && !ld_en && (dm_req || if_req);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = BUSY;
      BUSY:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      port_q     <= PORT_IF;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        port_q  <= dm_req ? PORT_DM : PORT_IF;
        addr_q  <= dm_req ? dm_addr : if_addr;
        we_q    <= dm_req && dm_we;
        wdata_q <= dm_wdata;
        cnt     <= 4'(WAIT_CYCLES);
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // Capture the read word at the end of RESP so it holds until the next ack.
      if (state == RESP && !we_q) begin
        if (port_q == PORT_IF) if_rdata_q <= ram_rdata;
        else                   dm_rdata_q <= ram_rdata;
      end
    end
  end

  // rst gates the RAM so a reset on the access edge abandons the write.
  always_comb begin
    ram_en    = !rst && (((state == IDLE) && ld_en) || ((state == BUSY) && (cnt == 4'd0)));
    ram_we    = (state == IDLE) ? 1'b1 : we_q;
    ram_addr  = (state == IDLE) ? ld_addr : addr_q;
    ram_wdata = (state == IDLE) ? ld_data : wdata_q;
  end

  mips_mem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
    .clk1  (clk1),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    if_ack   = (state == RESP) && (port_q == PORT_IF);
    dm_ack   = (state == RESP) && (port_q == PORT_DM);
    if_rdata = if_ack ? ram_rdata : if_rdata_q;
    dm_rdata = (dm_ack && !we_q) ? ram_rdata : dm_rdata_q;
    busy     = (state != IDLE);
  end

endmodule
